// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter : CPU / dual-DMA memory bus arbiter with read-only CPU stalls
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  output logic        rdy,
  input  logic        dma0_req,
  input  logic [15:0] dma0_addr,
  input  logic [7:0]  dma0_wdata,
  input  logic        dma0_rw,
  output logic        dma0_grant,
  output logic        dma0_ack,
  input  logic        dma1_req,
  input  logic [15:0] dma1_addr,
  input  logic [7:0]  dma1_wdata,
  input  logic        dma1_rw,
  output logic        dma1_grant,
  output logic        dma1_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rw
);

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DMA   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_COUNT = 4'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic [3:0] count_q, count_d;

  logic owner_req;
  logic owner_ack;
  logic pick_owner;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CPU;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      count_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    owner_req  = owner_q ? dma1_req : dma0_req;
    owner_ack  = (state_q == ST_DMA) && owner_req;
    // A tie goes to whoever did not own the previous burst.
    pick_owner = (dma0_req && dma1_req) ? ~last_owner_q : dma1_req;

    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;

    case (state_q)
      ST_CPU: begin
        if (dma0_req || dma1_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!(dma0_req || dma1_req)) begin
          state_d = ST_CPU;
        end else if (cpu_rw) begin
          state_d      = ST_DMA;
          owner_d      = pick_owner;
          last_owner_d = pick_owner;
          count_d      = 4'd0;
        end
      end
      ST_DMA: begin
        if (!owner_req) begin
          state_d = ST_CPU;
        end else begin
          count_d = count_q + 4'd1;
          if (count_q == LAST_COUNT) state_d = ST_CPU;
        end
      end
      default: state_d = ST_CPU;
    endcase
  end

  always_comb begin
    rdy        = (state_q == ST_CPU);
    dma0_grant = (state_q == ST_DMA) && !owner_q;
    dma1_grant = (state_q == ST_DMA) &&  owner_q;
    dma0_ack   = dma0_grant && dma0_req;
    dma1_ack   = dma1_grant && dma1_req;

    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_rw    = cpu_rw;
    if (state_q == ST_DMA) begin
      mem_addr  = owner_q ? dma1_addr  : dma0_addr;
      mem_wdata = owner_q ? dma1_wdata : dma0_wdata;
      // Without a transfer the bus idles as a read so memory is never written.
      mem_rw    = owner_ack ? (owner_q ? dma1_rw : dma0_rw) : 1'b1;
    end
  end

endmodule

`default_nettype wire
